// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array output row streamer:
// default geometry, the streamer state encoding and the row type.
package sa_pkg;

  localparam int DEF_D_W  = 8;
  localparam int DEF_SA_R = 16;
  localparam int DEF_SA_C = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  typedef logic [0:DEF_SA_C-1][DEF_D_W-1:0] row_t;

endpackage

// File: rtl/sa_row_max.sv
// Signed maximum over one row of elements, built as a balanced binary
// reduction tree. Unused leaves of a non-power-of-two row are padded with the
// most negative value so they never win a comparison.
module sa_row_max
  import sa_pkg::*;
#(
  parameter int D_W = DEF_D_W,
  parameter int N   = DEF_SA_C
) (
  input  logic [0:N-1][D_W-1:0] i_row,
  output logic [D_W-1:0]        o_max
);

  localparam int LVL = (N > 1) ? $clog2(N) : 0;
  localparam int P   = 1 << LVL;
  localparam logic [D_W-1:0] MIN_VAL = {1'b1, {(D_W-1){1'b0}}};

  logic [D_W-1:0] node [0:2*P-2];

  // Fill leaves, then reduce pairwise from the bottom level up to the root.
  always_comb begin
    for (int i = 0; i < 2*P-1; i++) node[i] = '0;
    for (int i = 0; i < N; i++) node[P-1+i] = i_row[i];
    for (int i = N; i < P; i++) node[P-1+i] = MIN_VAL;
    for (int i = P-2; i >= 0; i--) begin
      node[i] = ($signed(node[2*i+1]) > $signed(node[2*i+2])) ? node[2*i+1] : node[2*i+2];
    end
    o_max = node[0];
  end

endmodule

// File: rtl/sa_out_row_streamer.sv
// Captures a full SA_R x SA_C result matrix from the systolic array in one
// cycle, then streams it out row by row over a valid/ready handshake.
// Optional feature macro: SA_ROW_MAX_EN adds O_ROW_MAX, the signed maximum of
// the row currently presented on O_ROW.
module sa_out_row_streamer
  import sa_pkg::*;
#(
  parameter int D_W  = DEF_D_W,
  parameter int SA_R = DEF_SA_R,
  parameter int SA_C = DEF_SA_C
) (
  input  logic                               I_CLK,
  input  logic                               I_ASYN_RSTN,
  input  logic                               I_MAT_VLD,
  input  logic [0:SA_R-1][0:SA_C-1][D_W-1:0] I_MATRIX,
  output logic                               O_MAT_RDY,
  output logic                               O_OVERFLOW,
  output logic                               O_ROW_VLD,
  input  logic                               I_ROW_RDY,
  output logic [0:SA_C-1][D_W-1:0]           O_ROW,
  output logic [$clog2(SA_R)-1:0]            O_ROW_IDX,
  output logic                               O_ROW_LAST
`ifdef SA_ROW_MAX_EN
  ,
  output logic [D_W-1:0]                     O_ROW_MAX
`endif
);

  localparam int IDX_W = $clog2(SA_R);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SA_R - 1);

  state_t                             state_q, state_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic                               ovf_q, ovf_d;
  logic [0:SA_R-1][0:SA_C-1][D_W-1:0] buf_q, buf_d;

  // State, row index, sticky overflow and matrix buffer registers.
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
    if (!I_ASYN_RSTN) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      buf_q   <= buf_d;
    end
  end

  // Capture in IDLE, advance on handshake in STREAM, flag matrices offered while busy.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    ovf_d   = ovf_q | ((state_q == STREAM) & I_MAT_VLD);
    case (state_q)
      IDLE: begin
        if (I_MAT_VLD) begin
          buf_d   = I_MATRIX;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (I_ROW_RDY) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags come from state only; the row itself is a mux on the buffer.
  always_comb begin
    O_MAT_RDY  = (state_q == IDLE);
    O_ROW_VLD  = (state_q == STREAM);
    O_OVERFLOW = ovf_q;
    O_ROW      = buf_q[idx_q];
    O_ROW_IDX  = idx_q;
    O_ROW_LAST = (state_q == STREAM) && (idx_q == LAST_IDX);
  end

`ifdef SA_ROW_MAX_EN
  sa_row_max #(
    .D_W (D_W),
    .N   (SA_C)
  ) u_row_max (
    .i_row (buf_q[idx_q]),
    .o_max (O_ROW_MAX)
  );
`endif

endmodule

// File: tb/tb_sa_out_row_streamer.sv
// Directed self-checking bench for sa_out_row_streamer. Inputs change 1 ns
// after each rising edge and outputs are compared at that same point.
// Row-max checks are compiled in only when SA_ROW_MAX_EN is defined.
module tb_sa_out_row_streamer;
  import sa_pkg::*;

  typedef logic [0:15][0:15][7:0] mat_t;

  logic        I_CLK;
  logic        I_ASYN_RSTN;
  logic        I_MAT_VLD;
  mat_t        I_MATRIX;
  logic        O_MAT_RDY;
  logic        O_OVERFLOW;
  logic        O_ROW_VLD;
  logic        I_ROW_RDY;
  row_t        O_ROW;
  logic [3:0]  O_ROW_IDX;
  logic        O_ROW_LAST;
`ifdef SA_ROW_MAX_EN
  logic [7:0]  O_ROW_MAX;
`endif

  int checks   = 0;
  int failures = 0;

  mat_t mat_a, mat_b, mat_c, mat_m;

  sa_out_row_streamer #(
    .D_W  (8),
    .SA_R (16),
    .SA_C (16)
  ) dut (
    .I_CLK       (I_CLK),
    .I_ASYN_RSTN (I_ASYN_RSTN),
    .I_MAT_VLD   (I_MAT_VLD),
    .I_MATRIX    (I_MATRIX),
    .O_MAT_RDY   (O_MAT_RDY),
    .O_OVERFLOW  (O_OVERFLOW),
    .O_ROW_VLD   (O_ROW_VLD),
    .I_ROW_RDY   (I_ROW_RDY),
    .O_ROW       (O_ROW),
    .O_ROW_IDX   (O_ROW_IDX),
    .O_ROW_LAST  (O_ROW_LAST)
`ifdef SA_ROW_MAX_EN
    ,
    .O_ROW_MAX   (O_ROW_MAX)
`endif
  );

  // 10 ns clock.
  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  // Hard stop so a stuck design cannot hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic vld, input mat_t mat, input logic rdy);
    I_MAT_VLD = vld;
    I_MATRIX  = mat;
    I_ROW_RDY = rdy;
  endtask

  task automatic stepCycle();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  // Everything visible while row r of matrix m is being presented.
  task automatic checkRowState(input string tag, input mat_t m, input int r);
    checkOutput($sformatf("%s r%0d vld", tag, r), 128'(O_ROW_VLD), 128'(1));
    checkOutput($sformatf("%s r%0d matrdy", tag, r), 128'(O_MAT_RDY), 128'(0));
    checkOutput($sformatf("%s r%0d idx", tag, r), 128'(O_ROW_IDX), 128'(r));
    checkOutput($sformatf("%s r%0d row", tag, r), 128'(O_ROW), 128'(m[r]));
    checkOutput($sformatf("%s r%0d last", tag, r), 128'(O_ROW_LAST), 128'(r == 15));
  endtask

  // Idle (or reset) view: ready for a matrix, no row offered.
  task automatic checkIdle(input string tag);
    checkOutput({tag, " matrdy"}, 128'(O_MAT_RDY), 128'(1));
    checkOutput({tag, " vld"}, 128'(O_ROW_VLD), 128'(0));
    checkOutput({tag, " last"}, 128'(O_ROW_LAST), 128'(0));
  endtask

  // Linear sequence of directed scenarios.
  initial begin
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        mat_a[r][c] = 8'((r * 16) + c);
        mat_b[r][c] = 8'((r * 7) + (c * 3) + 1);
        mat_c[r][c] = 8'(255 - ((r * 16) + c) ^ 8'h3C);
        mat_m[r][c] = 8'h00;
      end
    end
    mat_m[0][0] = 8'h80;
    mat_m[0][1] = 8'h05;
    mat_m[0][2] = 8'hFF;
    mat_m[0][3] = 8'h7E;
    for (int c = 0; c < 16; c++) mat_m[1][c] = 8'h80;

    // Reset values.
    I_ASYN_RSTN = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    #12;
    checkIdle("reset");
    checkOutput("reset ovf", 128'(O_OVERFLOW), 128'(0));
    checkOutput("reset idx", 128'(O_ROW_IDX), 128'(0));
    checkOutput("reset row", 128'(O_ROW), 128'(0));
`ifdef SA_ROW_MAX_EN
    checkOutput("reset max", 128'(O_ROW_MAX), 128'(0));
`endif
    I_ASYN_RSTN = 1'b1;
    stepCycle();
    checkIdle("post-reset");

    // Capture and full-rate streaming of r*16+c.
    applyStimulus(1'b1, mat_a, 1'b1);
    stepCycle();
    I_MAT_VLD = 1'b0;
    for (int r = 0; r < 16; r++) begin
      checkRowState("stream", mat_a, r);
      stepCycle();
    end
    checkIdle("stream done");
    checkOutput("stream ovf", 128'(O_OVERFLOW), 128'(0));

    // Overflow pulse at row 3 and back-pressure at row 5.
    applyStimulus(1'b1, mat_b, 1'b1);
    stepCycle();
    I_MAT_VLD = 1'b0;
    for (int r = 0; r < 16; r++) begin
      checkRowState("bp", mat_b, r);
      if (r == 3) begin
        I_MAT_VLD = 1'b1;
        I_MATRIX  = mat_c;
      end
      if (r == 5) begin
        I_ROW_RDY = 1'b0;
        for (int k = 0; k < 3; k++) begin
          stepCycle();
          checkRowState($sformatf("hold%0d", k), mat_b, 5);
        end
        I_ROW_RDY = 1'b1;
      end
      stepCycle();
      I_MAT_VLD = 1'b0;
      if (r == 3) checkOutput("ovf set", 128'(O_OVERFLOW), 128'(1));
    end
    checkIdle("bp done");
    checkOutput("ovf sticky", 128'(O_OVERFLOW), 128'(1));

    // Reset in the middle of a stream, then a fresh capture.
    applyStimulus(1'b1, mat_a, 1'b1);
    stepCycle();
    I_MAT_VLD = 1'b0;
    for (int r = 0; r < 7; r++) stepCycle();
    checkRowState("pre-rst", mat_a, 7);
    I_ASYN_RSTN = 1'b0;
    #1;
    checkIdle("mid-rst");
    checkOutput("mid-rst idx", 128'(O_ROW_IDX), 128'(0));
    checkOutput("mid-rst ovf", 128'(O_OVERFLOW), 128'(0));
    checkOutput("mid-rst row", 128'(O_ROW), 128'(0));
    #3;
    I_ASYN_RSTN = 1'b1;
    applyStimulus(1'b1, mat_c, 1'b1);
    stepCycle();
    I_MAT_VLD = 1'b0;
    checkRowState("after-rst", mat_c, 0);
    stepCycle();
    checkRowState("after-rst", mat_c, 1);
    for (int r = 1; r < 16; r++) stepCycle();
    checkIdle("after-rst done");

    // Back-to-back: valid held high, second capture SA_R+1 cycles later.
    applyStimulus(1'b1, mat_a, 1'b1);
    stepCycle();
    I_MATRIX = mat_b;
    for (int r = 0; r < 16; r++) begin
      checkRowState("b2b1", mat_a, r);
      stepCycle();
    end
    checkIdle("b2b gap");
    stepCycle();
    I_MAT_VLD = 1'b0;
    checkRowState("b2b2", mat_b, 0);
    checkOutput("b2b ovf", 128'(O_OVERFLOW), 128'(1));
    for (int r = 0; r < 16; r++) stepCycle();
    checkIdle("b2b done");

`ifdef SA_ROW_MAX_EN
    // Signed row maximum on mixed-sign and all-minimum rows.
    applyStimulus(1'b1, mat_m, 1'b1);
    stepCycle();
    I_MAT_VLD = 1'b0;
    checkOutput("max mixed", 128'(O_ROW_MAX), 128'(8'h7E));
    stepCycle();
    checkOutput("max all80", 128'(O_ROW_MAX), 128'(8'h80));
    stepCycle();
    checkOutput("max zeros", 128'(O_ROW_MAX), 128'(8'h00));
    for (int r = 2; r < 16; r++) stepCycle();
    checkIdle("max done");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
